// File: rtl/pwrbtn_press_ctrl.sv
// rtl/pwrbtn_press_ctrl.sv - power button short/long press classifier
//
// Classifies a debounced, active-low power button into short and long presses
// timed in milliseconds, and owns the edge_clear handshake of the upstream
// edge synchronizer so each press/release edge is serviced exactly once.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   t30p5us       one-clk strobe that also steps the upstream synchronizer
//   t1ms          one-clk 1 ms timebase strobe
//   enable        classification enable; low aborts a press in progress
//   btn_level     synchronized button level (0 = pressed)
//   btn_fall      sticky press-edge flag from upstream
//   btn_rise      sticky release-edge flag from upstream
//   edge_clear    clears both upstream flags on a t30p5us cycle
//   short_press   one-clk pulse on release of a valid short press
//   long_press    one-clk pulse when the hold reaches LONG_MS
//   press_active  high while a press is being timed
//   hold_ms       measured hold time, saturating at LONG_MS, held after release

module pwrbtn_press_ctrl #(
    parameter logic [15:0] SHORT_MIN_MS = 16'd50,
    parameter logic [15:0] LONG_MS      = 16'd4000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        t30p5us,
    input  logic        t1ms,
    input  logic        enable,
    input  logic        btn_level,
    input  logic        btn_fall,
    input  logic        btn_rise,
    output logic        edge_clear,
    output logic        short_press,
    output logic        long_press,
    output logic        press_active,
    output logic [15:0] hold_ms
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS_CLR = 3'd1,
        S_PRESSED   = 3'd2,
        S_LONG_HELD = 3'd3,
        S_REL_CLR   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] hold_nxt;
    logic [15:0] hold_inc;
    logic        lvl_seen;
    logic        lvl_seen_nxt;
    logic        lvl_release;
    logic        short_nxt;
    logic        long_nxt;
    logic        edge_clear_nxt;
    logic        press_active_nxt;

    // Saturating increment: the hold counter stops at LONG_MS and never wraps.
    assign hold_inc = (hold_ms >= LONG_MS) ? LONG_MS : hold_ms + 16'd1;

    // Level sanity check: the button reading released (with no rise flag)
    // on two consecutive 1 ms ticks counts as a release. lvl_seen records
    // the first such tick; this is the second.
    assign lvl_release = t1ms && btn_level && !btn_rise && lvl_seen;

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold_ms;
        lvl_seen_nxt = 1'b0;
        short_nxt    = 1'b0;
        long_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                // A rise flag in IDLE is either stray or arrived together with
                // the fall; neither is a trustworthy press, so just discard.
                if (btn_rise) begin
                    state_nxt = S_REL_CLR;
                end else if (btn_fall) begin
                    if (enable) begin
                        state_nxt = S_PRESS_CLR;
                        hold_nxt  = 16'd0;
                    end else begin
                        state_nxt = S_REL_CLR;
                    end
                end
            end

            S_PRESS_CLR: begin
                if (!enable) begin
                    state_nxt = S_REL_CLR;
                end else begin
                    if (t1ms) begin
                        hold_nxt = hold_inc;
                    end
                    if (t30p5us) begin
                        state_nxt = S_PRESSED;
                    end
                end
            end

            S_PRESSED: begin
                if (!enable) begin
                    state_nxt = S_REL_CLR;
                end else begin
                    if (btn_level && !btn_rise) begin
                        lvl_seen_nxt = lvl_seen | t1ms;
                    end
                    if (t1ms) begin
                        hold_nxt = hold_inc;
                    end
                    // Reaching LONG_MS wins over a same-cycle release; the
                    // release flag stays set and is picked up in LONG_HELD.
                    if (t1ms && (hold_inc >= LONG_MS)) begin
                        long_nxt  = 1'b1;
                        state_nxt = S_LONG_HELD;
                    end else if (btn_rise) begin
                        short_nxt = (hold_nxt >= SHORT_MIN_MS);
                        state_nxt = S_REL_CLR;
                    end else if (lvl_release) begin
                        state_nxt = S_REL_CLR;
                    end
                end
            end

            S_LONG_HELD: begin
                if (btn_level && !btn_rise) begin
                    lvl_seen_nxt = lvl_seen | t1ms;
                end
                if (!enable || btn_rise || lvl_release) begin
                    state_nxt = S_REL_CLR;
                end
            end

            S_REL_CLR: begin
                if (t30p5us) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Registered outputs follow the next state so edge_clear is high for
        // every cycle spent in a clear state, including the strobe cycle.
        edge_clear_nxt   = (state_nxt == S_PRESS_CLR) || (state_nxt == S_REL_CLR);
        press_active_nxt = (state_nxt == S_PRESS_CLR) || (state_nxt == S_PRESSED) ||
                           (state_nxt == S_LONG_HELD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            hold_ms      <= 16'd0;
            lvl_seen     <= 1'b0;
            edge_clear   <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            press_active <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_ms      <= hold_nxt;
            lvl_seen     <= lvl_seen_nxt;
            edge_clear   <= edge_clear_nxt;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            press_active <= press_active_nxt;
        end
    end

endmodule

// File: tb/tb_pwrbtn_press_ctrl.sv
// tb/tb_pwrbtn_press_ctrl.sv - self-checking bench for pwrbtn_press_ctrl
module tb_pwrbtn_press_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        t30p5us = 1'b0;
    logic        t1ms = 1'b0;
    logic        enable = 1'b1;
    logic        btn_level = 1'b1;
    logic        btn_fall = 1'b0;
    logic        btn_rise = 1'b0;
    logic        edge_clear;
    logic        short_press;
    logic        long_press;
    logic        press_active;
    logic [15:0] hold_ms;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected pulses: {short_press, long_press, hold_ms}
    logic [17:0] exp_q[$];

    pwrbtn_press_ctrl #(
        .SHORT_MIN_MS(16'd5),
        .LONG_MS     (16'd20)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .t30p5us     (t30p5us),
        .t1ms        (t1ms),
        .enable      (enable),
        .btn_level   (btn_level),
        .btn_fall    (btn_fall),
        .btn_rise    (btn_rise),
        .edge_clear  (edge_clear),
        .short_press (short_press),
        .long_press  (long_press),
        .press_active(press_active),
        .hold_ms     (hold_ms)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pulse the DUT produces must match the next expected one.
    always @(negedge clk) begin
        if (reset_n && (short_press || long_press)) begin
            logic [17:0] e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: got short=%0b long=%0b hold=%0d, required none",
                         short_press, long_press, hold_ms);
            end else begin
                e = exp_q.pop_front();
                if ({short_press, long_press, hold_ms} !== e) begin
                    n_fail++;
                    $display("FAIL pulse_match: got short=%0b long=%0b hold=%0d, required short=%0b long=%0b hold=%0d",
                             short_press, long_press, hold_ms, e[17], e[16], e[15:0]);
                end
            end
        end
    end

    // One strobe cycle; emulates the upstream synchronizer clearing its flags
    // when edge_clear is high on a t30p5us cycle.
    task automatic strobe(input bit s30, input bit s1);
        logic ec;
        @(negedge clk);
        ec = edge_clear;
        t30p5us = s30;
        t1ms = s1;
        @(negedge clk);
        t30p5us = 1'b0;
        t1ms = 1'b0;
        if (s30 && ec) begin
            btn_fall = 1'b0;
            btn_rise = 1'b0;
        end
    endtask

    task automatic ms_ticks(input int n);
        for (int i = 0; i < n; i++) strobe(1'b0, 1'b1);
    endtask

    task automatic press_btn();
        @(negedge clk);
        btn_level = 1'b0;
        btn_fall = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_btn();
        @(negedge clk);
        btn_level = 1'b1;
        btn_rise = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({edge_clear, short_press, long_press, press_active, hold_ms} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {edge_clear, short_press, long_press, press_active, hold_ms});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_short_press();
        exp_q.push_back({1'b1, 1'b0, 16'd8});
        press_btn();
        n_tests++;
        if ({edge_clear, press_active, hold_ms} !== {1'b1, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL short_enter: got ec=%0b pa=%0b hold=%0d, required ec=1 pa=1 hold=0",
                     edge_clear, press_active, hold_ms);
        end
        strobe(1'b1, 1'b0);
        n_tests++;
        if ({edge_clear, press_active} !== 2'b01) begin
            n_fail++;
            $display("FAIL short_clr_done: got ec=%0b pa=%0b, required ec=0 pa=1", edge_clear, press_active);
        end
        ms_ticks(8);
        n_tests++;
        if (hold_ms !== 16'd8) begin
            n_fail++;
            $display("FAIL short_hold: got %0d, required 8", hold_ms);
        end
        release_btn();
        n_tests++;
        if ({edge_clear, press_active} !== 2'b10) begin
            n_fail++;
            $display("FAIL short_release: got ec=%0b pa=%0b, required ec=1 pa=0", edge_clear, press_active);
        end
        strobe(1'b1, 1'b0);
        n_tests++;
        if ({edge_clear, hold_ms, exp_q.size() == 0} !== {1'b0, 16'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL short_end: got ec=%0b hold=%0d pending=%0d, required ec=0 hold=8 pending=0",
                     edge_clear, hold_ms, exp_q.size());
        end
    endtask

    task automatic test_long_press();
        exp_q.push_back({1'b0, 1'b1, 16'd20});
        press_btn();
        strobe(1'b1, 1'b0);
        ms_ticks(19);
        n_tests++;
        if (exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL long_early: got pending=%0d, required 1", exp_q.size());
        end
        ms_ticks(11);
        n_tests++;
        if ({hold_ms, press_active, exp_q.size() == 0} !== {16'd20, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL long_frozen: got hold=%0d pa=%0b pending=%0d, required hold=20 pa=1 pending=0",
                     hold_ms, press_active, exp_q.size());
        end
        release_btn();
        strobe(1'b1, 1'b0);
        n_tests++;
        if ({edge_clear, press_active, hold_ms} !== {1'b0, 1'b0, 16'd20}) begin
            n_fail++;
            $display("FAIL long_end: got ec=%0b pa=%0b hold=%0d, required ec=0 pa=0 hold=20",
                     edge_clear, press_active, hold_ms);
        end
    endtask

    task automatic test_glitch_press();
        press_btn();
        strobe(1'b1, 1'b0);
        ms_ticks(3);
        release_btn();
        strobe(1'b1, 1'b0);
        n_tests++;
        if ({edge_clear, press_active, hold_ms} !== {1'b0, 1'b0, 16'd3}) begin
            n_fail++;
            $display("FAIL glitch_end: got ec=%0b pa=%0b hold=%0d, required ec=0 pa=0 hold=3",
                     edge_clear, press_active, hold_ms);
        end
    endtask

    task automatic test_simultaneous_flags();
        @(negedge clk);
        btn_fall = 1'b1;
        btn_rise = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({edge_clear, press_active} !== 2'b10) begin
            n_fail++;
            $display("FAIL simul_relclr: got ec=%0b pa=%0b, required ec=1 pa=0", edge_clear, press_active);
        end
        strobe(1'b1, 1'b0);
        n_tests++;
        if ({edge_clear, btn_fall, btn_rise, hold_ms} !== {3'b000, 16'd3}) begin
            n_fail++;
            $display("FAIL simul_end: got ec=%0b fall=%0b rise=%0b hold=%0d, required all 0 hold=3",
                     edge_clear, btn_fall, btn_rise, hold_ms);
        end
    endtask

    task automatic test_abort();
        press_btn();
        strobe(1'b1, 1'b0);
        ms_ticks(10);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({edge_clear, press_active, hold_ms} !== {1'b1, 1'b0, 16'd10}) begin
            n_fail++;
            $display("FAIL abort_relclr: got ec=%0b pa=%0b hold=%0d, required ec=1 pa=0 hold=10",
                     edge_clear, press_active, hold_ms);
        end
        strobe(1'b1, 1'b0);
        enable = 1'b1;
        release_btn();
        strobe(1'b1, 1'b0);
        n_tests++;
        if ({edge_clear, press_active, hold_ms} !== {1'b0, 1'b0, 16'd10}) begin
            n_fail++;
            $display("FAIL abort_end: got ec=%0b pa=%0b hold=%0d, required ec=0 pa=0 hold=10",
                     edge_clear, press_active, hold_ms);
        end
    endtask

    // Exactly SHORT_MIN_MS qualifies; the first tick shares its cycle with the
    // t30p5us strobe that ends PRESS_CLR, so both must be honoured.
    task automatic test_short_boundary();
        exp_q.push_back({1'b1, 1'b0, 16'd5});
        press_btn();
        strobe(1'b1, 1'b1);
        n_tests++;
        if ({edge_clear, hold_ms} !== {1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL both_strobes: got ec=%0b hold=%0d, required ec=0 hold=1", edge_clear, hold_ms);
        end
        ms_ticks(4);
        release_btn();
        strobe(1'b1, 1'b0);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL boundary_short: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_level_release();
        press_btn();
        strobe(1'b1, 1'b0);
        ms_ticks(6);
        @(negedge clk);
        btn_level = 1'b1;
        strobe(1'b0, 1'b1);
        n_tests++;
        if (press_active !== 1'b1) begin
            n_fail++;
            $display("FAIL level_one_tick: got pa=%0b, required 1", press_active);
        end
        strobe(1'b0, 1'b1);
        n_tests++;
        if ({edge_clear, press_active} !== 2'b10) begin
            n_fail++;
            $display("FAIL level_release: got ec=%0b pa=%0b, required ec=1 pa=0", edge_clear, press_active);
        end
        strobe(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_press();
        press_btn();
        strobe(1'b1, 1'b0);
        ms_ticks(12);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({edge_clear, short_press, long_press, press_active, hold_ms} !== 20'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, required 0",
                     {edge_clear, short_press, long_press, press_active, hold_ms});
        end
        btn_level = 1'b1;
        btn_fall = 1'b0;
        btn_rise = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_q.push_back({1'b1, 1'b0, 16'd8});
        press_btn();
        strobe(1'b1, 1'b0);
        ms_ticks(8);
        release_btn();
        strobe(1'b1, 1'b0);
        n_tests++;
        if ({exp_q.size() == 0, edge_clear, press_active} !== 3'b100) begin
            n_fail++;
            $display("FAIL post_reset_short: got pending=%0d ec=%0b pa=%0b, required pending=0 ec=0 pa=0",
                     exp_q.size(), edge_clear, press_active);
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_press();
        test_glitch_press();
        test_simultaneous_flags();
        test_abort();
        test_short_boundary();
        test_level_release();
        test_reset_mid_press();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
